// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and word/address types for the pipelined
// register file (regfile_sb) and its scoreboard.
package regfile_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          NREGS_DEF   = 32;
    localparam int          SP_IDX_DEF  = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'h2ffc;
    localparam int          X17_IDX     = 17;
    localparam int          AW_DEF      = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for hazard detection.
// A reservation from decode sets a bit, a writeback clears it, and flush
// squashes all outstanding reservations. Register 0 is never busy.
// Build option: REGFILE_BYPASS_EN makes the per-port busy lookup follow the
// same-cycle writeback, matching the forwarded read data.
module regfile_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    input  logic               flush,
    output logic [NUM_RD-1:0]  rd_busy,
    output logic [NREGS-1:0]   busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Next busy vector: flush or writeback clear first, then a reservation
    // sets, so the newer producer wins over a completing older one.
    always_comb begin
        // NOTE: every combinational output gets a default on entry so no path
        // leaves it unassigned, which would otherwise infer a latch.
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy register: cleared on reset, otherwise takes the computed next state.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    // Per-port busy lookup, optionally overridden by a same-cycle writeback.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr != '0) && (rd_addr[k*AW +: AW] == wr_addr)) begin
                rd_busy[k] = rsv_en && (rsv_addr == wr_addr);
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with NUM_RD combinational
// read ports, one writeback port, a busy-bit scoreboard and a configurable
// stack-pointer reset value. r0 reads as zero and ignores writes.
// Build option: REGFILE_BYPASS_EN forwards the writeback value to matching
// read ports and to x17 in the same cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int          XLEN    = XLEN_DEF,
    parameter int          NREGS   = NREGS_DEF,
    parameter int          NUM_RD  = 2,
    parameter int          SP_IDX  = SP_IDX_DEF,
    parameter logic [31:0] SP_INIT = SP_INIT_DEF,
    localparam int         AW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    input  logic                   flush,
    output logic [XLEN-1:0]        x17,
    output logic [NREGS-1:0]       busy_vec
);

    // SP_INIT is given as 32 bits; size it to the register width.
    localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

    logic [XLEN-1:0] regs [NREGS];

`ifdef REGFILE_BYPASS_EN
    logic wr_fwd;
    assign wr_fwd = wr_en && (wr_addr != '0);
`endif

    // Register array: architectural reset values, otherwise writeback (r0 never written).
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because software relies on
            // zeroed registers and a valid sp, so it is built from flops
            // rather than a reset-less RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read muxes: r0 forced to zero, optional same-cycle writeback forwarding.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_fwd && (rd_addr[k*AW +: AW] == wr_addr)) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
            end
`endif
        end
    end

    // x17 tap for ecall/halt detection; absent registers read as zero.
    if (NREGS > X17_IDX) begin : g_x17
        // Direct view of r17, with the same forwarding as the read ports.
        always_comb begin
            x17 = regs[X17_IDX];
`ifdef REGFILE_BYPASS_EN
            if (wr_fwd && (wr_addr == AW'(X17_IDX))) begin
                x17 = wr_data;
            end
`endif
        end
    end else begin : g_no_x17
        assign x17 = '0;
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .AW     (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the single-issue integer register file, built for the pipelined core.
- Adds N read ports, a per-register scoreboard (busy bits) for hazard detection, optional write-to-read bypass, and a configurable stack-pointer reset value.
- Sits between decode (reads, reservations) and writeback (writes, busy clear).
- Exposes x17 for ecall/halt detection, as the existing top level expects.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2; AW = clog2(NREGS).
- NUM_RD, 2, number of independent read ports (1..4).
- SP_IDX, 2, index of the stack pointer register.
- SP_INIT, 32'h2ffc, reset value of the stack pointer register; truncated or zero-extended to XLEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register, combinational.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- rsv_en  in  1  reserve (mark busy) request from decode.
- rsv_addr  in  AW  register to reserve.
- flush  in  1  clears all busy bits at the next edge (pipeline squash).
- x17  out  XLEN  current value of r[17], combinational.
- busy_vec  out  NREGS  full scoreboard, for debug and the hazard unit.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge.
- Reset values: at an edge with reset=1, every register is set to 0 except r[SP_IDX], which is set to SP_INIT. All busy bits are cleared. Writes and reservations in that cycle are ignored.
- Reset resulting outputs: rd_data of any port addressing SP_IDX = SP_INIT, all other rd_data = 0, x17 = 0, rd_busy = 0, busy_vec = 0.
- Register 0:
  - reads always return 0 and rd_busy=0;
  - writes to address 0 are discarded;
  - reserving address 0 is a no-op, so busy[0] is permanently 0.
- Writes: at a rising edge with wr_en=1 and wr_addr!=0, r[wr_addr] <= wr_data. Write latency is one cycle, visible from the next cycle.
- Reads: combinational per port. Any number of ports may address the same register.
- Scoreboard updates, per register i at each edge:
  - set when rsv_en and rsv_addr==i;
  - cleared when wr_en and wr_addr==i;
  - set and clear on the same register in the same cycle: set wins, because a newer producer overrides.
  - flush=1 clears every busy bit; a reservation in the same cycle is still applied (flush precedes set). A write in the flush cycle still updates data.
  - busy is not a lock: writes to a non-busy register are accepted normally.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - a port whose rd_addr equals wr_addr with wr_en=1 and wr_addr!=0 returns wr_data in the same cycle (write-through forwarding);
  - its rd_busy reads 0 that cycle unless rsv_en targets the same register in the same cycle;
  - x17 is also forwarded.
- Undefined: reads return the stored value only; the new value appears the cycle after the write, and rd_busy reflects the registered busy bit.

Decomposition:
- Package regfile_pkg holds:
  - localparams XLEN_DEF=32, NREGS_DEF=32, SP_IDX_DEF=2, SP_INIT_DEF=32'h2ffc, X17_IDX=17;
  - typedef reg_addr_t (AW bits) and typedef xword_t (XLEN bits).
- One sub-module: regfile_scoreboard, containing the busy vector, set/clear/flush priority logic and the per-port busy lookup.
- The data array and read muxes stay in regfile_sb.

Test Plan:
- Reset with SP_INIT=32'h2ffc, then read all registers on both ports -> r2=0x2ffc, all others 0, busy_vec=0, x17=0.
- Write 0xDEADBEEF to x5 at cycle t while reading x5 on port 0 -> bypass off: old value 0 at t, 0xDEADBEEF at t+1; bypass on: 0xDEADBEEF at t.
- Write 0x1234 to x0, then read x0 on every port -> 0; reserve x0 -> busy_vec[0] stays 0.
- Reserve x7 (cycle t), write x7 (cycle t+3) -> rd_busy for x7 = 1 during t+1..t+3, 0 at t+4.
- Same-cycle rsv_en=1 and wr_en=1 to x9 -> data updated, busy[9]=1 afterwards.
- Reserve x3 and x4, then flush=1 with rsv_en to x6 -> busy_vec has only bit 6 set.
- Write x17=93, then assert reset mid-operation with wr_en=1 to x8 -> after the edge: x17=0, r8=0, r2=0x2ffc.
